qos_stream_arbiter: RTL and testbench
=====================================

Name: qos_stream_arbiter

Overview:
- Packet-level stream arbiter that merges STREAM_COUNT valid/ready input streams onto one output stream.
- Supersedes the fixed-priority grant logic with three additions:
  - per-stream QoS priority fields;
  - round-robin tie-break among streams with equal QoS;
  - grant locking for the whole packet, until the beat with last is accepted.
- Sits between the stream sources and the shared downstream sink.

Parameters:
- STREAM_COUNT, 4: number of input streams, 2..16.
- T_DATA_WIDTH, 8: data width of each stream, in bits.
- T_QOS_WIDTH, 4: QoS field width; a larger value means higher priority.
- T_ID_WIDTH, $clog2(STREAM_COUNT): width of the granted-stream index.
- AGING_LIMIT, 8: lost-arbitration threshold; used only when AGING_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- s_data  in  STREAM_COUNT*T_DATA_WIDTH  packed input data; stream i occupies bits [i*T_DATA_WIDTH +: T_DATA_WIDTH].
- s_qos  in  STREAM_COUNT*T_QOS_WIDTH  packed per-stream QoS; sampled only in IDLE.
- s_last  in  STREAM_COUNT  end-of-packet flag per stream.
- s_valid  in  STREAM_COUNT  valid per stream.
- s_ready  out  STREAM_COUNT  ready per stream.
- m_data  out  T_DATA_WIDTH  output data.
- m_qos  out  T_QOS_WIDTH  QoS latched at grant for the current packet.
- m_id  out  T_ID_WIDTH  index of the granted stream.
- m_last  out  1  output end-of-packet.
- m_valid  out  1  output valid.
- m_ready  in  1  output ready.

Behaviour:
- Reset (nrst=0, async):
  - state=IDLE, grant index=0, m_qos=0, round-robin pointer last_grant=STREAM_COUNT-1 (so stream 0 wins the first tie).
  - m_valid=0, s_ready=0, m_last=0, m_data=0, m_id=0.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - All s_ready=0 and m_valid=0.
  - Candidates = streams with s_valid=1.
  - The winner is the candidate with maximum s_qos.
  - Ties are resolved round-robin: the first tied candidate searching upward, modulo STREAM_COUNT, from last_grant+1.
  - If any candidate exists: register the winner into grant index and m_id, latch its QoS into m_qos, set last_grant=winner, and go to BUSY next cycle.
  - If there are no candidates, stay in IDLE; no registered value changes.
- BUSY (combinational pass-through of the granted stream g):
  - m_valid=s_valid[g], m_data=s_data[g], m_last=s_last[g].
  - s_ready[g]=m_ready; s_ready of every other stream is 0.
  - A beat transfers when m_valid and m_ready are both 1.
  - A transfer with m_last=1 returns the FSM to IDLE next cycle. Otherwise it stays in BUSY.
  - Valid deasserting mid-packet keeps the lock; other streams are never granted mid-packet.
- Latency and throughput:
  - 1 cycle from valid in IDLE to first m_valid.
  - There is one IDLE bubble cycle between packets, so peak throughput is N/(N+1) for N-beat packets.
- QoS changes while in BUSY have no effect on the current packet; m_qos is stable for the whole packet.
- Single-beat packets: IDLE, then BUSY with last=1 on the first transfer, then back to IDLE.
- Reset asserted mid-packet aborts the packet immediately. After release, arbitration restarts from the reset pointer. No partial-packet recovery.
- m_data, m_last and m_id are 0 in IDLE.

Optional Feature:
- Macro: AGING_EN.
- Defined:
  - Each stream has a saturating wait counter of width $clog2(AGING_LIMIT+1). All counters reset to 0.
  - On each IDLE arbitration, every candidate that loses increments its counter; the winner's counter clears to 0.
  - A stream with counter >= AGING_LIMIT is treated as QoS = all-ones, i.e. 2^T_QOS_WIDTH-1, for winner selection only. m_qos still reports its real latched s_qos.
  - Ties among aged streams are resolved by the same round-robin rule.
  - Counters of streams with s_valid=0 hold their value.
- Undefined: the counters and the AGING_LIMIT logic are absent, and selection uses pure QoS plus round-robin.

Test Plan:
- Reset state: assert nrst=0 mid-packet with m_ready=1 -> same cycle m_valid=0, all s_ready=0; after release, the first tie goes to stream 0.
- QoS priority: STREAM_COUNT=4, all valid, qos={1,7,3,7} for streams 0..3, 2-beat packets:
  - first grant is stream 1, m_qos=7;
  - with stream 1 still presenting afterwards, the next grant is stream 3 (round-robin among the QoS 7 ties).
- Packet lock: stream 2 granted on a 4-beat packet; stream 0 raises valid with qos=15 at beat 2 and m_ready toggles 1,0,1,1,1 -> all 4 beats come from stream 2, s_ready[0]=0 throughout, stream 0 is granted after the 1-cycle bubble.
- Backpressure: m_ready=0 for 5 cycles mid-packet -> m_data, m_id and m_qos hold, no beat is lost or duplicated, s_ready[g]=0.
- Single-beat fairness: all 4 streams send continuous 1-beat packets at equal qos=2 -> grant order 0,1,2,3,0, one transfer every 2 cycles.
- AGING_EN, AGING_LIMIT=3: stream 0 qos=0 valid; stream 1 qos=5 sends back-to-back packets -> stream 0 is granted on the 4th arbitration and its counter clears to 0; without AGING_EN, stream 0 is never granted.

Source files
------------

// File: rtl/qos_stream_if.sv
// Stream-merge bus: STREAM_COUNT packed input streams plus one merged output stream.
// 'master' is the sources/sink side, 'slave' is the arbiter side.
interface qos_stream_if #(
  parameter int STREAM_COUNT = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS_WIDTH  = 4,
  parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT)
);
  logic [STREAM_COUNT*T_DATA_WIDTH-1:0] s_data;
  logic [STREAM_COUNT*T_QOS_WIDTH-1:0]  s_qos;
  logic [STREAM_COUNT-1:0]              s_last;
  logic [STREAM_COUNT-1:0]              s_valid;
  logic [STREAM_COUNT-1:0]              s_ready;
  logic [T_DATA_WIDTH-1:0]              m_data;
  logic [T_QOS_WIDTH-1:0]               m_qos;
  logic [T_ID_WIDTH-1:0]                m_id;
  logic                                 m_last;
  logic                                 m_valid;
  logic                                 m_ready;

  modport master (
    output s_data, s_qos, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_qos, m_id, m_last, m_valid
  );
  modport slave (
    input  s_data, s_qos, s_last, s_valid, m_ready,
    output s_ready, m_data, m_qos, m_id, m_last, m_valid
  );
endinterface

// File: rtl/qos_stream_arbiter.sv
// Packet-locked QoS stream arbiter with round-robin tie-break among equal QoS.
// Define AGING_EN to promote streams that lost AGING_LIMIT arbitrations to top QoS.
module qsa_lane #(
  parameter int T_QOS_WIDTH = 4,
  parameter int AGING_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   valid,
  input  logic                   arb,
  input  logic                   win,
  input  logic [T_QOS_WIDTH-1:0] qos,
  output logic [T_QOS_WIDTH-1:0] eff_qos
);
`ifdef AGING_EN
  localparam int CW = $clog2(AGING_LIMIT + 1);
  logic [CW-1:0] cnt;

  // Losers count up (saturating), the winner clears; idle streams hold.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt <= '0;
    else if (arb && valid) begin
      if (win) cnt <= '0;
      else if (cnt < CW'(AGING_LIMIT)) cnt <= cnt + 1'b1;
    end
  end

  assign eff_qos = (cnt >= CW'(AGING_LIMIT)) ? '1 : qos;
`else
  localparam int unused_lim = AGING_LIMIT;
  logic unused_aging;
  assign unused_aging = ^{clk, nrst, valid, arb, win};
  assign eff_qos = qos;
`endif
endmodule

module qos_stream_arbiter #(
  parameter int STREAM_COUNT = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS_WIDTH  = 4,
  parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT),
  parameter int AGING_LIMIT  = 8
) (
  input logic        clk,
  input logic        nrst,
  qos_stream_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  if (STREAM_COUNT < 2 || STREAM_COUNT > 16) begin : g_bad_cfg
    $error("qos_stream_arbiter: STREAM_COUNT must be 2..16");
  end

  state_t state_q, state_d;
  logic [T_ID_WIDTH-1:0]  grant_q, last_grant_q, win_idx, idx;
  logic [T_ID_WIDTH:0]    sum;
  logic [T_QOS_WIDTH-1:0] m_qos_q, best;
  logic                   win_found, arb_en;

  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] data_a;
  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]  qos_a, eff_qos;

  assign data_a = bus.s_data;
  assign qos_a  = bus.s_qos;
  assign arb_en = (state_q == IDLE) && win_found;

  for (genvar i = 0; i < STREAM_COUNT; i++) begin : g_lane
    qsa_lane #(.T_QOS_WIDTH(T_QOS_WIDTH), .AGING_LIMIT(AGING_LIMIT)) u_lane (
      .clk     (clk),
      .nrst    (nrst),
      .valid   (bus.s_valid[i]),
      .arb     (arb_en),
      .win     (win_idx == T_ID_WIDTH'(i)),
      .qos     (qos_a[i]),
      .eff_qos (eff_qos[i])
    );
  end

  // Scan in round-robin order from last_grant+1; strict '>' keeps the first of equal QoS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    best      = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 1; k <= STREAM_COUNT; k++) begin
      sum = {1'b0, last_grant_q} + (T_ID_WIDTH+1)'(k);
      if (sum >= (T_ID_WIDTH+1)'(STREAM_COUNT)) sum = sum - (T_ID_WIDTH+1)'(STREAM_COUNT);
      idx = sum[T_ID_WIDTH-1:0];
      if (bus.s_valid[idx] && (!win_found || eff_qos[idx] > best)) begin
        win_found = 1'b1;
        win_idx   = idx;
        best      = eff_qos[idx];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.s_ready = '0;
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.m_last  = 1'b0;
    bus.m_id    = '0;
    case (state_q)
      IDLE: if (win_found) state_d = BUSY;
      BUSY: begin
        bus.m_valid          = bus.s_valid[grant_q];
        bus.m_data           = data_a[grant_q];
        bus.m_last           = bus.s_last[grant_q];
        bus.m_id             = grant_q;
        bus.s_ready[grant_q] = bus.m_ready;
        if (bus.s_valid[grant_q] && bus.m_ready && bus.s_last[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= T_ID_WIDTH'(STREAM_COUNT - 1);
      m_qos_q      <= '0;
    end else begin
      state_q <= state_d;
      if (arb_en) begin
        grant_q      <= win_idx;
        last_grant_q <= win_idx;
        m_qos_q      <= qos_a[win_idx];
      end
    end
  end

  assign bus.m_qos = m_qos_q;
endmodule

// File: tb/tb_qos_stream_arbiter.sv
// Directed bench for qos_stream_arbiter: priority, RR ties, packet lock, backpressure, reset, aging.
module tb_qos_stream_arbiter;
  localparam int SC = 4;
  localparam int DW = 8;
  localparam int QW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic nrst;
  int   checks = 0;
  int   errors = 0;
  int   xfers = 0;
  int   x0;
  int   qos_tab[4] = '{1, 7, 3, 7};
  int   age_exp[8];

  always #5 clk = ~clk;

  qos_stream_if #(.STREAM_COUNT(SC), .T_DATA_WIDTH(DW), .T_QOS_WIDTH(QW), .T_ID_WIDTH(IW)) bus ();

  qos_stream_arbiter #(
    .STREAM_COUNT(SC), .T_DATA_WIDTH(DW), .T_QOS_WIDTH(QW), .T_ID_WIDTH(IW), .AGING_LIMIT(3)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always @(posedge clk)
    if (nrst && bus.m_valid && bus.m_ready) xfers <= xfers + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_s(input int i, input logic [7:0] d, input logic [3:0] q,
                       input logic l, input logic v);
    bus.s_data[i*DW +: DW] = d;
    bus.s_qos[i*QW +: QW]  = q;
    bus.s_last[i]          = l;
    bus.s_valid[i]         = v;
  endtask

  task automatic clear_all();
    for (int i = 0; i < SC; i++) set_s(i, 8'h00, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef AGING_EN
    age_exp = '{1, 1, 1, 0, 1, 1, 1, 0};
`else
    age_exp = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
    nrst = 1'b0;
    clear_all();
    bus.m_ready = 1'b0;
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_m_id",    32'(bus.m_id), 0);
    chk("rst_m_qos",   32'(bus.m_qos), 0);
    chk("rst_m_data",  32'(bus.m_data), 0);
    step(); step();
    nrst = 1'b1;

    // QoS priority with round-robin among the two QoS-7 streams
    for (int i = 0; i < SC; i++) set_s(i, 8'(8'h10 + i), 4'(qos_tab[i]), 1'b0, 1'b1);
    bus.m_ready = 1'b1;
    #1;
    chk("idle_m_valid", 32'(bus.m_valid), 0);
    step();
    chk("qos_g1_id",    32'(bus.m_id), 1);
    chk("qos_g1_qos",   32'(bus.m_qos), 7);
    chk("qos_g1_data",  32'(bus.m_data), 32'h11);
    chk("qos_g1_ready", 32'(bus.s_ready), 32'b0010);
    step();
    bus.s_last[1] = 1'b1;
    #1;
    chk("qos_g1_last", 32'(bus.m_last), 1);
    step();
    bus.s_last[1] = 1'b0;
    #1;
    chk("bubble_valid", 32'(bus.m_valid), 0);
    chk("bubble_id",    32'(bus.m_id), 0);
    step();
    chk("qos_g2_id",  32'(bus.m_id), 3);
    chk("qos_g2_qos", 32'(bus.m_qos), 7);
    step();
    bus.s_last[3] = 1'b1;
    step();
    clear_all();

    // Packet lock on stream 2 while stream 0 shows up with top QoS
    set_s(2, 8'h21, 4'd1, 1'b0, 1'b1);
    step();
    x0 = xfers;
    chk("lock_id",   32'(bus.m_id), 2);
    chk("lock_b1",   32'(bus.m_data), 32'h21);
    chk("lock_rdy1", 32'(bus.s_ready), 32'b0100);
    step();
    set_s(2, 8'h22, 4'd1, 1'b0, 1'b1);
    set_s(0, 8'h05, 4'd15, 1'b0, 1'b1);
    bus.m_ready = 1'b0;
    #1;
    chk("lock_rdy0", 32'(bus.s_ready), 0);
    chk("lock_hold", 32'(bus.m_data), 32'h22);
    step();
    bus.m_ready = 1'b1;
    #1;
    chk("lock_b2",   32'(bus.m_data), 32'h22);
    chk("lock_rdy2", 32'(bus.s_ready), 32'b0100);
    step();
    set_s(2, 8'h23, 4'd1, 1'b0, 1'b1);
    #1;
    chk("lock_b3_id", 32'(bus.m_id), 2);
    chk("lock_b3",    32'(bus.m_data), 32'h23);
    step();
    set_s(2, 8'h24, 4'd1, 1'b1, 1'b1);
    #1;
    chk("lock_b4",      32'(bus.m_data), 32'h24);
    chk("lock_b4_last", 32'(bus.m_last), 1);
    step();
    set_s(2, 8'h00, 4'd0, 1'b0, 1'b0);
    #1;
    chk("lock_xfers",  xfers - x0, 4);
    chk("lock_bubble", 32'(bus.m_valid), 0);
    step();
    chk("lock_next_id",  32'(bus.m_id), 0);
    chk("lock_next_qos", 32'(bus.m_qos), 15);

    // Backpressure plus a QoS change that must not disturb the latched m_qos
    set_s(0, 8'h05, 4'd3, 1'b0, 1'b1);
    bus.m_ready = 1'b0;
    x0 = xfers;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_data", 32'(bus.m_data), 32'h05);
      chk("bp_id",   32'(bus.m_id), 0);
      chk("bp_qos",  32'(bus.m_qos), 15);
      chk("bp_rdy",  32'(bus.s_ready), 0);
      step();
    end
    chk("bp_noxfer", xfers - x0, 0);
    bus.m_ready = 1'b1;
    #1;
    chk("bp_rdy_on", 32'(bus.s_ready), 32'b0001);
    step();
    set_s(0, 8'h06, 4'd3, 1'b1, 1'b1);
    #1;
    chk("bp_b2", 32'(bus.m_data), 32'h06);
    step();
    clear_all();
    #1;
    chk("bp_xfers", xfers - x0, 2);
    chk("bp_idle",  32'(bus.m_valid), 0);

    // Reset mid-packet
    set_s(1, 8'h31, 4'd1, 1'b0, 1'b1);
    step();
    chk("mid_valid", 32'(bus.m_valid), 1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.m_valid), 0);
    chk("mid_rst_ready", 32'(bus.s_ready), 0);
    step();
    nrst = 1'b1;
    clear_all();

    // Single-beat fairness at equal QoS, pointer restarted by reset
    for (int i = 0; i < SC; i++) set_s(i, 8'(8'h40 + i), 4'd2, 1'b1, 1'b1);
    x0 = xfers;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fair_id",   32'(bus.m_id), k % 4);
      chk("fair_data", 32'(bus.m_data), 32'h40 + (k % 4));
      step();
      chk("fair_bubble", 32'(bus.m_valid), 0);
    end
    chk("fair_xfers", xfers - x0, 5);
    clear_all();

    // Starvation scenario: low-QoS stream 0 against back-to-back stream 1
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    set_s(0, 8'h50, 4'd0, 1'b1, 1'b1);
    set_s(1, 8'h51, 4'd5, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("age_id",  32'(bus.m_id), age_exp[k]);
      chk("age_qos", 32'(bus.m_qos), (age_exp[k] == 0) ? 0 : 5);
      step();
    end
    clear_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
